// File: rtl/relay_seq_pkg.sv
// relay_seq_pkg
// Shared definitions for the FSA sequencer: state count, counter width,
// the state indices at which the decoder may end an instruction early,
// the index and phase types, and the terminal-state test used by the top.
package relay_seq_pkg;

  // FSA states in a full instruction (state 1 is index 0)
  localparam int NUM_STATES = 24;

  // Default width of the completed-instruction counter
  localparam int CNT_W = 16;

  // Zero-based indices of the states that an abort bit can terminate
  localparam int ABORT_8  = 7;
  localparam int ABORT_10 = 9;
  localparam int ABORT_12 = 11;
  localparam int ABORT_14 = 13;

  // Last state of a full-length instruction
  localparam int LAST_IDX = NUM_STATES - 1;

  typedef logic [4:0] fsa_idx_t;

  typedef enum logic {PH_A, PH_B} fsa_phase_t;

  // True when the state at idx ends the instruction. Each abort bit only
  // matters at its own state, so several bits set at once cannot interfere.
  function automatic logic is_terminal(input fsa_idx_t idx, input logic [3:0] abort);
    logic term;
    term = (idx == fsa_idx_t'(LAST_IDX))
         | ((idx == fsa_idx_t'(ABORT_8))  & abort[0])
         | ((idx == fsa_idx_t'(ABORT_10)) & abort[1])
         | ((idx == fsa_idx_t'(ABORT_12)) & abort[2])
         | ((idx == fsa_idx_t'(ABORT_14)) & abort[3]);
    return term;
  endfunction

endpackage

// File: rtl/fsa_ring.sv
// fsa_ring
// State register of the FSA: a state index and a two-phase sub-state,
// plus the one-hot decode driven out to the instruction decoder.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   adv             advance one phase on this clock edge
//   terminal        current state ends the instruction (used leaving PH_B)
//   idx, phase      registered state index and phase
//   fsa_out         one-hot current state
//   fsa_out_prime   copy of fsa_out during PH_B, zero during PH_A
module fsa_ring
  import relay_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  adv,
  input  logic                  terminal,
  output fsa_idx_t              idx,
  output fsa_phase_t            phase,
  output logic [NUM_STATES-1:0] fsa_out,
  output logic [NUM_STATES-1:0] fsa_out_prime
);

  fsa_idx_t   idx_q,   idx_d;
  fsa_phase_t phase_q, phase_d;

  // Next state: PH_A always moves to PH_B of the same state; leaving PH_B
  // either wraps to state 1 or steps to the next state.
  always_comb begin
    idx_d   = idx_q;
    phase_d = phase_q;
    if (adv) begin
      if (phase_q == PH_A) begin
        phase_d = PH_B;
      end else begin
        phase_d = PH_A;
        if (terminal) begin
          idx_d = '0;
        end else begin
          idx_d = idx_q + fsa_idx_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      phase_q <= PH_A;
    end else begin
      idx_q   <= idx_d;
      phase_q <= phase_d;
    end
  end

  // One-hot decode straight from the registers, so it is glitch-free with
  // respect to the decoder inputs.
  always_comb begin
    fsa_out = '0;
    for (int k = 0; k < NUM_STATES; k++) begin
      fsa_out[k] = (idx_q == fsa_idx_t'(k));
    end
    fsa_out_prime = (phase_q == PH_B) ? fsa_out : '0;
  end

  assign idx   = idx_q;
  assign phase = phase_q;

endmodule

// File: rtl/fsa_sequencer.sv
// fsa_sequencer
// Finite-state automaton that sequences the instruction decoder. Each
// instruction walks states 1..24 (two phases per state) unless the decoder
// raises the abort bit belonging to state 8, 10, 12 or 14, which ends the
// instruction at that state. Front-panel run/step decide when to advance.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   run             level, free-run one phase per clock
//   step            one-clock pulse, single phase advance while halted
//   abort[3:0]      early-end request: [0]=8 [1]=10 [2]=12 [3]=14
//   fsa_out         one-hot current state
//   fsa_out_prime   fsa_out during the second phase of a state, else zero
//   instr_start     first phase of state 1
//   instr_done      final phase of the terminating state
//   instr_count     completed instructions, wraps silently
module fsa_sequencer
  import relay_seq_pkg::*;
#(
  parameter int CNT_W = relay_seq_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step,
  input  logic [3:0]            abort,
  output logic [NUM_STATES-1:0] fsa_out,
  output logic [NUM_STATES-1:0] fsa_out_prime,
  output logic                  instr_start,
  output logic                  instr_done,
  output logic [CNT_W-1:0]      instr_count
);

  fsa_idx_t         idx;
  fsa_phase_t       phase;
  logic             adv;
  logic             term_cond;
  logic [CNT_W-1:0] count_q, count_d;

  // step only matters while halted; while running it is swallowed
  assign adv = run | (~run & step);

  // abort is looked at combinationally, so instr_done may rise partway
  // through the phase when the decoder asserts abort late.
  assign term_cond   = is_terminal(idx, abort);
  assign instr_done  = (phase == PH_B) & term_cond;
  assign instr_start = (idx == '0) & (phase == PH_A);

  fsa_ring u_ring (
    .clk           (clk),
    .reset         (reset),
    .adv           (adv),
    .terminal      (term_cond),
    .idx           (idx),
    .phase         (phase),
    .fsa_out       (fsa_out),
    .fsa_out_prime (fsa_out_prime)
  );

  // An instruction is counted on the same edge that returns to state 1
  always_comb begin
    count_d = count_q;
    if (adv && instr_done) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;

endmodule

// File: tb/tb_fsa_sequencer.sv
// tb_fsa_sequencer
// Self-checking bench for fsa_sequencer. A behavioural model tracks the
// state number (1..24), the half within the state and the completed
// instruction total; every output is compared after each clock edge.
// A second instance with a 4-bit counter exercises the wrap of the
// instruction counter within a short run.
module tb_fsa_sequencer;

  logic        clk;
  logic        reset;
  logic        run_i;
  logic        step_i;
  logic [3:0]  abort_i;

  logic [23:0] fsa_out, fsa_out_prime;
  logic        instr_start, instr_done;
  logic [15:0] instr_count;

  logic [23:0] w4_fsa_out, w4_fsa_out_prime;
  logic        w4_instr_start, w4_instr_done;
  logic [3:0]  w4_instr_count;

  int check_cnt = 0;
  int err_cnt   = 0;

  // model state
  int m_s;
  int m_h;
  int m_cnt;

  fsa_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run_i),
    .step          (step_i),
    .abort         (abort_i),
    .fsa_out       (fsa_out),
    .fsa_out_prime (fsa_out_prime),
    .instr_start   (instr_start),
    .instr_done    (instr_done),
    .instr_count   (instr_count)
  );

  fsa_sequencer #(.CNT_W(4)) dut_w4 (
    .clk           (clk),
    .reset         (reset),
    .run           (run_i),
    .step          (step_i),
    .abort         (abort_i),
    .fsa_out       (w4_fsa_out),
    .fsa_out_prime (w4_fsa_out_prime),
    .instr_start   (w4_instr_start),
    .instr_done    (w4_instr_done),
    .instr_count   (w4_instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_term(input int s, input logic [3:0] a);
    return (s == 24) || (s == 8 && a[0]) || (s == 10 && a[1]) ||
           (s == 12 && a[2]) || (s == 14 && a[3]);
  endfunction

  task automatic model_reset();
    m_s   = 1;
    m_h   = 0;
    m_cnt = 0;
  endtask

  task automatic model_edge();
    if (run_i || step_i) begin
      if (m_h == 0) begin
        m_h = 1;
      end else if (m_term(m_s, abort_i)) begin
        m_s = 1;
        m_h = 0;
        m_cnt++;
      end else begin
        m_s++;
        m_h = 0;
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    logic [23:0] exp_out;
    logic [23:0] exp_prime;
    exp_out   = 24'd1 << (m_s - 1);
    exp_prime = (m_h == 1) ? exp_out : 24'd0;
    check_val("fsa_out",       {8'd0, fsa_out},       {8'd0, exp_out});
    check_val("fsa_out_prime", {8'd0, fsa_out_prime}, {8'd0, exp_prime});
    check_val("instr_start",   {31'd0, instr_start},  {31'd0, (m_s == 1 && m_h == 0)});
    check_val("instr_done",    {31'd0, instr_done},   {31'd0, (m_h == 1 && m_term(m_s, abort_i))});
    check_val("instr_count",   {16'd0, instr_count},  {16'd0, m_cnt[15:0]});
    check_val("count_w4",      {28'd0, w4_instr_count}, {28'd0, m_cnt[3:0]});
    check_val("onehot",        {31'd0, $onehot(fsa_out)}, 32'd1);
  endtask

  // one clock: inputs already driven, update model at the edge, sample 1 later
  task automatic apply_stimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_output();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_output();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    run_i   = 1'b0;
    step_i  = 1'b0;
    abort_i = 4'd0;
    model_reset();
    #2;
    check_output();
    @(negedge clk);
    reset = 1'b0;

    // async reset while free-running at state 5, phase 1
    $display("[TB] async reset mid-instruction");
    run_i = 1'b1;
    apply_stimulus(9);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_output();
    @(negedge clk);
    reset = 1'b0;

    // full 24-state instruction
    $display("[TB] full-length instruction");
    run_i = 1'b1;
    abort_i = 4'd0;
    apply_stimulus(47);
    check_val("done_at_48", {31'd0, instr_done}, 32'd1);
    apply_stimulus(1);
    check_val("count_after_full", {16'd0, instr_count}, 32'd1);

    // early terminations
    $display("[TB] abort end@8, end@14, all bits");
    abort_i = 4'b0001;
    apply_stimulus(32);
    abort_i = 4'b1000;
    apply_stimulus(56);
    abort_i = 4'b1111;
    apply_stimulus(32);

    // abort[1] raised only during state 8 must not end the instruction
    $display("[TB] misplaced abort ignored");
    abort_i = 4'd0;
    for (int i = 0; i < 48; i++) begin
      abort_i = (m_s == 8) ? 4'b0010 : 4'b0000;
      apply_stimulus(1);
    end
    abort_i = 4'd0;

    // single stepping from reset
    $display("[TB] single step");
    run_i = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step_i = 1'b1;
      apply_stimulus(1);
      step_i = 1'b0;
      apply_stimulus(2);
    end
    run_i  = 1'b1;
    step_i = 1'b1;
    apply_stimulus(4);
    step_i = 1'b0;

    // randomized run/step/abort
    $display("[TB] random stimulus");
    for (int i = 0; i < 400; i++) begin
      run_i   = ($urandom_range(0, 3) != 0);
      step_i  = 1'($urandom_range(0, 1));
      abort_i = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      apply_stimulus(1);
    end

    // counter wrap on the 4-bit instance, short instructions
    $display("[TB] counter wrap");
    run_i   = 1'b1;
    step_i  = 1'b0;
    abort_i = 4'b0001;
    do_reset();
    apply_stimulus(17 * 16 + 4);
    check_val("w4_wrapped", {28'd0, w4_instr_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
